// File: rtl/ng_adr_pkg.sv
// ng_adr_pkg
// Shared definitions for the address stage: register widths, S-region codes,
// the highest central-register address, the fixed-fixed bank numbers and the
// restore-sequencer state encoding.
// No ports.
package ng_adr_pkg;

    localparam int S_W    = 12;
    localparam int BANK_W = 4;
    localparam int ADDR_W = BANK_W + 10;

    // S[11:10] selects the memory region.
    typedef enum logic [1:0] {
        REG_ERASABLE = 2'b00,
        REG_BANKED   = 2'b01,
        REG_FIXED1   = 2'b10,
        REG_FIXED2   = 2'b11
    } region_e;

    // Highest address of the central-register block.
    localparam logic [S_W-1:0] S_CENTRAL_MAX = 12'o0027;

    // Banks that the two fixed-fixed regions are hard-wired to.
    localparam logic [BANK_W-1:0] FF_BANK1 = 4'd1;
    localparam logic [BANK_W-1:0] FF_BANK2 = 4'd2;

    typedef enum logic {
        SEQ_IDLE = 1'b0,
        SEQ_PEND = 1'b1
    } seq_state_e;

endpackage

// File: rtl/ng_adr_seq_if.sv
// ng_adr_seq_if
// Bus bundle between the control pulse generator / monitor and the address
// stage. The slave modport is the address stage's view.
//   WRITE_BUS, WS_n, WBK_n, RBK_n, SBWG_n, WE_n, CLR_SEQERR_n : into the stage
//   Address, GTR_1777, GTR_27, BANK_BUS, S_OUT,
//   RESTORE_PEND, SEQ_ERR                                      : out of the stage
interface ng_adr_seq_if;
    import ng_adr_pkg::*;

    logic [15:0]       WRITE_BUS;
    logic              WS_n;
    logic              WBK_n;
    logic              RBK_n;
    logic              SBWG_n;
    logic              WE_n;
    logic              CLR_SEQERR_n;

    logic [ADDR_W-1:0] Address;
    logic              GTR_1777;
    logic              GTR_27;
    logic [15:0]       BANK_BUS;
    logic [S_W-1:0]    S_OUT;
    logic              RESTORE_PEND;
    logic              SEQ_ERR;

    modport master (
        output WRITE_BUS, WS_n, WBK_n, RBK_n, SBWG_n, WE_n, CLR_SEQERR_n,
        input  Address, GTR_1777, GTR_27, BANK_BUS, S_OUT, RESTORE_PEND, SEQ_ERR
    );

    modport slave (
        input  WRITE_BUS, WS_n, WBK_n, RBK_n, SBWG_n, WE_n, CLR_SEQERR_n,
        output Address, GTR_1777, GTR_27, BANK_BUS, S_OUT, RESTORE_PEND, SEQ_ERR
    );

endinterface

// File: rtl/ng_adr_decode.sv
// ng_adr_decode
// Purely combinational address decode from the registered S and BANK.
//   s        in  12  S register
//   bank     in  4   fixed-memory BANK register
//   address  out 14  physical memory address
//   gtr_1777 out 1   1 when S is in erasable memory (S <= 0o1777)
//   gtr_27   out 1   1 when S addresses a central register (S <= 0o27)
module ng_adr_decode
    import ng_adr_pkg::*;
(
    input  logic [S_W-1:0]    s,
    input  logic [BANK_W-1:0] bank,
    output logic [ADDR_W-1:0] address,
    output logic              gtr_1777,
    output logic              gtr_27
);

    region_e region;

    always_comb begin
        region   = region_e'(s[11:10]);
        address  = '0;
        gtr_1777 = (region == REG_ERASABLE);
        gtr_27   = (s <= S_CENTRAL_MAX);
        unique case (region)
            REG_ERASABLE: address = {{BANK_W{1'b0}}, s[9:0]};
            REG_BANKED:   address = {bank, s[9:0]};   // BANK=0 aliases ROM words 0..1023
            REG_FIXED1:   address = {FF_BANK1, s[9:0]};
            REG_FIXED2:   address = {FF_BANK2, s[9:0]};
            default:      address = '0;
        endcase
    end

endmodule

// File: rtl/ng_adr_seq.sv
// ng_adr_seq
// Address stage in front of the memory/G/parity block. Holds S and BANK,
// forms the physical address and region flags, and runs the restore
// sequencer that checks every erasable read is written back before S moves.
//   CLK2   in  1  system clock, rising edge
//   RESET  in  1  synchronous active-high reset
//   bus    slave modport of ng_adr_seq_if (strobes, write bus, address,
//          flags, BANK_BUS, S_OUT, RESTORE_PEND, SEQ_ERR)
//
// Restore sequencer:
//   state    | meaning
//   SEQ_IDLE | no erasable read outstanding
//   SEQ_PEND | erasable cell read into G, write-back (WE) still owed
module ng_adr_seq
    import ng_adr_pkg::*;
(
    input  logic        CLK2,
    input  logic        RESET,
    ng_adr_seq_if.slave bus
);

    logic [S_W-1:0]    s_reg;
    logic [BANK_W-1:0] bank_reg;
    seq_state_e        state;
    logic              restore_pend;
    logic              seq_err;

    logic              gtr_1777;
    logic              gtr_27;
    logic              real_cell;
    logic              seq_err_set;
    logic              unused_bus_bits;

    ng_adr_decode u_decode (
        .s        (s_reg),
        .bank     (bank_reg),
        .address  (bus.Address),
        .gtr_1777 (gtr_1777),
        .gtr_27   (gtr_27)
    );

    // Central registers live in flip-flops, not core, so need no restore.
    assign real_cell = gtr_1777 && !gtr_27;

    // A pending restore is violated by S changing or a second read, unless
    // the write-back happens in that same cycle.
    assign seq_err_set = (state == SEQ_PEND) && bus.WE_n && (!bus.WS_n || !bus.SBWG_n);

    always_ff @(posedge CLK2) begin
        if (RESET) begin
            s_reg        <= '0;
            bank_reg     <= '0;
            state        <= SEQ_IDLE;
            restore_pend <= 1'b0;
            seq_err      <= 1'b0;
        end else begin
            if (!bus.WS_n)  s_reg    <= bus.WRITE_BUS[S_W-1:0];
            if (!bus.WBK_n) bank_reg <= bus.WRITE_BUS[13:10];

            unique case (state)
                SEQ_IDLE: begin
                    // A simultaneous read and write-back is a complete cycle.
                    if (!bus.SBWG_n && bus.WE_n && real_cell) begin
                        state        <= SEQ_PEND;
                        restore_pend <= 1'b1;
                    end
                end
                SEQ_PEND: begin
                    if (!bus.WE_n || !bus.WS_n) begin
                        state        <= SEQ_IDLE;
                        restore_pend <= 1'b0;
                    end
                end
                default: begin
                    state        <= SEQ_IDLE;
                    restore_pend <= 1'b0;
                end
            endcase

            if (!bus.CLR_SEQERR_n)
                seq_err <= 1'b0;
            else if (seq_err_set)
                seq_err <= 1'b1;
        end
    end

    assign bus.GTR_1777     = gtr_1777;
    assign bus.GTR_27       = gtr_27;
    assign bus.BANK_BUS     = bus.RBK_n ? 16'h0000 : {2'b00, bank_reg, 10'b0};
    assign bus.S_OUT        = s_reg;
    assign bus.RESTORE_PEND = restore_pend;
    assign bus.SEQ_ERR      = seq_err;

    assign unused_bus_bits = ^bus.WRITE_BUS[15:14];

endmodule

// File: tb/tb_ng_adr_seq.sv
// tb_ng_adr_seq
// Directed vector table for the listed scenarios and corner cases, then a
// randomized run checked against a behavioural model of S/BANK/restore rules.
module tb_ng_adr_seq;

    logic CLK2;
    logic RESET;

    ng_adr_seq_if bus ();

    ng_adr_seq dut (
        .CLK2  (CLK2),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK2 = 1'b0;
    always #5 CLK2 = ~CLK2;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    typedef struct {
        logic        rst;
        logic        ws_n, wbk_n, rbk_n, sbwg_n, we_n, clr_n;
        logic [15:0] wbus;
        logic [13:0] addr;
        logic        g1777, g27;
        logic [11:0] s;
        logic        pend, err;
        logic [15:0] bb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic ws_n, input logic wbk_n, input logic rbk_n,
        input logic sbwg_n, input logic we_n, input logic clr_n, input logic [15:0] wbus,
        input logic [13:0] addr, input logic g1777, input logic g27, input logic [11:0] s,
        input logic pend, input logic err, input logic [15:0] bb);
        vec_t v;
        v.rst = rst; v.ws_n = ws_n; v.wbk_n = wbk_n; v.rbk_n = rbk_n;
        v.sbwg_n = sbwg_n; v.we_n = we_n; v.clr_n = clr_n; v.wbus = wbus;
        v.addr = addr; v.g1777 = g1777; v.g27 = g27; v.s = s;
        v.pend = pend; v.err = err; v.bb = bb;
        return v;
    endfunction

    task automatic drive(input logic rst, input logic ws_n, input logic wbk_n, input logic rbk_n,
                         input logic sbwg_n, input logic we_n, input logic clr_n, input logic [15:0] wbus);
        RESET            = rst;
        bus.WS_n         = ws_n;
        bus.WBK_n        = wbk_n;
        bus.RBK_n        = rbk_n;
        bus.SBWG_n       = sbwg_n;
        bus.WE_n         = we_n;
        bus.CLR_SEQERR_n = clr_n;
        bus.WRITE_BUS    = wbus;
    endtask

    task automatic check_outputs(input string tag, input logic [13:0] addr, input logic g1777,
                                 input logic g27, input logic [11:0] s, input logic pend,
                                 input logic err, input logic [15:0] bb);
        chk({tag, "_addr"}, 32'(bus.Address),      32'(addr));
        chk({tag, "_g1777"}, 32'(bus.GTR_1777),    32'(g1777));
        chk({tag, "_g27"}, 32'(bus.GTR_27),        32'(g27));
        chk({tag, "_s"}, 32'(bus.S_OUT),           32'(s));
        chk({tag, "_pend"}, 32'(bus.RESTORE_PEND), 32'(pend));
        chk({tag, "_err"}, 32'(bus.SEQ_ERR),       32'(err));
        chk({tag, "_bankbus"}, 32'(bus.BANK_BUS),  32'(bb));
    endtask

    // Reference address from region arithmetic on S.
    function automatic logic [13:0] ref_addr(input int s, input int bank);
        int off;
        off = s % 1024;
        if (s < 1024)      return 14'(off);
        else if (s < 2048) return 14'(bank * 1024 + off);
        else if (s < 3072) return 14'(1024 + off);
        else               return 14'(2048 + off);
    endfunction

    int  m_s, m_bank;
    bit  m_awaiting, m_err;

    initial begin
        drive(1, 1, 1, 1, 1, 1, 1, 16'h0000);

        //           rst ws wbk rbk sbwg we clr wbus       addr                  g17 g27 s        pend err bb
        vecs.push_back(mk(1, 1, 1, 1, 1, 1, 1, 16'h0000, 14'o0,                 1, 1, 12'o0,    0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o30,   14'o30,                1, 0, 12'o30,   0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 16'h1C00, 14'o30,                1, 0, 12'o30,   0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o2345, 14'(7*1024 + 'o345),   0, 0, 12'o2345, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o6012, 14'(2*1024 + 'o12),    0, 0, 12'o6012, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o100,  14'o100,               1, 0, 12'o100,  0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o100,               1, 0, 12'o100,  1, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, 16'h0000, 14'o100,               1, 0, 12'o100,  0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o100,               1, 0, 12'o100,  1, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o200,  14'o200,               1, 0, 12'o200,  0, 1, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0000, 14'o200,               1, 0, 12'o200,  0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o20,   14'o20,                1, 1, 12'o20,   0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o20,                1, 1, 12'o20,   0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o4000, 14'd1024,              0, 0, 12'o4000, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'd1024,              0, 0, 12'o4000, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 0, 0, 1, 1, 1, 16'h1400, 14'd1024,              0, 0, 12'o4000, 0, 0, 16'h1400));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o27,   14'o27,                1, 1, 12'o27,   0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o30,   14'o30,                1, 0, 12'o30,   0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o1777, 14'o1777,              1, 0, 12'o1777, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o1777,              1, 0, 12'o1777, 1, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 16'h0000, 14'o1777,              1, 0, 12'o1777, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 16'h0000, 14'o1777,              1, 0, 12'o1777, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, 16'h0000, 14'o1777,              1, 0, 12'o1777, 0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o1777,              1, 0, 12'o1777, 1, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o1777,              1, 0, 12'o1777, 1, 1, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 1, 16'o2000, 14'(5*1024),           0, 0, 12'o2000, 0, 1, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 16'h0000, 14'(5*1024),           0, 0, 12'o2000, 0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 1, 16'o300,  14'o300,               1, 0, 12'o300,  0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o300,               1, 0, 12'o300,  1, 0, 16'h0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 0, 16'o400,  14'o400,               1, 0, 12'o400,  0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 1, 1, 16'h0000, 14'o400,               1, 0, 12'o400,  1, 0, 16'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 16'hFFFF, 14'o0,                 1, 1, 12'o0,    0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 1, 16'h0000, 14'o0,                 1, 1, 12'o0,    0, 0, 16'h0));

        @(negedge CLK2);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].ws_n, vecs[i].wbk_n, vecs[i].rbk_n,
                  vecs[i].sbwg_n, vecs[i].we_n, vecs[i].clr_n, vecs[i].wbus);
            @(posedge CLK2);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].addr, vecs[i].g1777, vecs[i].g27,
                          vecs[i].s, vecs[i].pend, vecs[i].err, vecs[i].bb);
        end

        // Randomized phase, starting from a reset.
        drive(1, 1, 1, 1, 1, 1, 1, 16'h0000);
        @(posedge CLK2);
        #1;
        m_s = 0; m_bank = 0; m_awaiting = 0; m_err = 0;

        for (int c = 0; c < 600; c++) begin
            logic        r_rst, r_ws, r_wbk, r_rbk, r_sbwg, r_we, r_clr;
            logic [15:0] r_wbus;
            bit          erasable_core, violation;

            r_rst  = ($urandom_range(0, 59) == 0);
            r_ws   = ($urandom_range(0, 3) != 0);
            r_wbk  = ($urandom_range(0, 5) != 0);
            r_rbk  = ($urandom_range(0, 2) != 0);
            r_sbwg = ($urandom_range(0, 2) != 0);
            r_we   = ($urandom_range(0, 3) != 0);
            r_clr  = ($urandom_range(0, 11) != 0);
            r_wbus = 16'($urandom);
            if ($urandom_range(0, 1) == 0) r_wbus[11:0] = 12'($urandom_range(0, 'o2100));
            drive(r_rst, r_ws, r_wbk, r_rbk, r_sbwg, r_we, r_clr, r_wbus);

            // Reference update from the discipline rules.
            if (r_rst) begin
                m_s = 0; m_bank = 0; m_awaiting = 0; m_err = 0;
            end else begin
                erasable_core = (m_s < 1024) && (m_s > 'o27);
                violation = 0;
                if (!m_awaiting) begin
                    if (!r_sbwg && r_we && erasable_core) m_awaiting = 1;
                end else if (!r_we) begin
                    m_awaiting = 0;
                end else if (!r_ws) begin
                    violation = 1;
                    m_awaiting = 0;
                end else if (!r_sbwg) begin
                    violation = 1;
                end
                if (!r_clr) m_err = 0;
                else if (violation) m_err = 1;
                if (!r_ws)  m_s = int'(r_wbus[11:0]);
                if (!r_wbk) m_bank = int'(r_wbus[13:10]);
            end

            @(posedge CLK2);
            #1;
            check_outputs($sformatf("rnd%0d", c), ref_addr(m_s, m_bank), m_s < 1024, m_s <= 'o27,
                          12'(m_s), m_awaiting, m_err,
                          r_rbk ? 16'h0000 : 16'(m_bank * 1024));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ng_adr_seq.md
Name: ng_adr_seq

Overview:
- Address stage directly upstream of the combined memory/G-register/parity block.
- Holds the 12-bit S register and the 4-bit fixed-memory BANK register.
- Forms the 14-bit physical memory address and the GTR_1777 / GTR_27 select flags that the memory stage consumes.
- Contains a restore sequencer that enforces the core-memory discipline: every erasable read (SBWG) is followed by a write-back (WE) before S changes.

Parameters:
- S_W, 12, width of S register.
- BANK_W, 4, width of BANK register.
- ADDR_W, 14, physical address width (must equal BANK_W + 10).

Ports:
- CLK2  in  1  system clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- WRITE_BUS  in  16  internal write bus.
- WS_n  in  1  active-low: load S from WRITE_BUS[11:0].
- WBK_n  in  1  active-low: load BANK from WRITE_BUS[13:10].
- RBK_n  in  1  active-low: drive BANK onto BANK_BUS[13:10].
- SBWG_n  in  1  active-low: memory read into G (same pulse as memory stage).
- WE_n  in  1  active-low: erasable write-back (same pulse as memory stage).
- CLR_SEQERR_n  in  1  active-low: clear sticky sequence error.
- Address  out  14  physical memory address.
- GTR_1777  out  1  negative logic: 1 when S <= 0o1777 (erasable), 0 otherwise.
- GTR_27  out  1  negative logic: 1 when S <= 0o27 (central registers), 0 otherwise.
- BANK_BUS  out  16  {2'b0, BANK, 10'b0} when RBK_n=0, else 16'h0000.
- S_OUT  out  12  current S, for monitor.
- RESTORE_PEND  out  1  1 while an erasable read awaits write-back.
- SEQ_ERR  out  1  sticky discipline-violation flag.

Behaviour:
Reset and registers
- RESET=1 at a clock edge clears S, BANK, sequencer (IDLE) and SEQ_ERR, regardless of any other input.
- After reset: Address=0, GTR_1777=1, GTR_27=1, RESTORE_PEND=0, SEQ_ERR=0.
- S and BANK load on the edge where their pulse is low. WS_n and WBK_n in the same cycle both load.
- Address and flags are combinational from registered S/BANK, so they are valid the cycle after load (1-cycle latency). They are stable for a whole cycle, as the synchronous RAM/ROM in the memory stage requires.

Address map, decoded from S[11:10]
- 00: erasable. Address = {4'b0000, S[9:0]}.
- 01: banked fixed. Address = {BANK, S[9:0]}. BANK=0 maps to ROM words 0..1023; no trap.
- 10: fixed-fixed bank 1. Address = {4'd1, S[9:0]}.
- 11: fixed-fixed bank 2. Address = {4'd2, S[9:0]}.

Flags
- GTR_1777 = (S[11:10]==2'b00).
- GTR_27 = (S <= 12'o0027).

Restore sequencer (states IDLE, PEND)
- IDLE -> PEND: SBWG_n=0 while GTR_1777=1 and GTR_27=0 (real erasable cell).
- PEND -> IDLE: WE_n=0.
- PEND with WS_n=0 and WE_n=1 (S changes before restore): set SEQ_ERR, go IDLE.
- PEND with SBWG_n=0 and WE_n=1 (second read before restore): set SEQ_ERR, stay PEND.
- PEND with WE_n=0 and WS_n=0 together: legal restore; S loads; go IDLE.
- SBWG_n=0 and WE_n=0 together in IDLE: no state change.
- WE_n=0 in IDLE: no effect.
- SBWG on fixed memory or on S <= 0o27: no effect.
- RESTORE_PEND = (state==PEND).

SEQ_ERR
- Sticky. Cleared only by CLR_SEQERR_n=0 or RESET.
- If a set condition and a clear occur in the same cycle, the clear wins.

Reset mid-operation
- RESET in PEND returns to IDLE with no error.

Decomposition:
- Shared package (ng_adr_pkg): region codes (ERASABLE, BANKED, FIXED1, FIXED2), constant octal 0o27, fixed-fixed bank numbers 1 and 2, sequencer state encoding.
- One natural sub-module: ng_adr_decode, purely combinational (S, BANK -> Address, GTR_1777, GTR_27).
- Registers and sequencer stay in ng_adr_seq.

Test Plan:
- Reset then WS_n with WRITE_BUS=0o0030 -> next cycle Address=14'o0030, GTR_1777=1, GTR_27=0.
- WBK_n with WRITE_BUS[13:10]=4'o7, then WS_n with S=0o2345 -> Address={4'o7,10'o345}, GTR_1777=0. Repeat with S=0o6012 -> Address={4'd2,10'o012}.
- S=0o100: SBWG_n pulse -> RESTORE_PEND=1; WE_n pulse -> RESTORE_PEND=0, SEQ_ERR=0.
- S=0o100: SBWG_n, then WS_n (S=0o200) without WE -> SEQ_ERR=1, RESTORE_PEND=0. CLR_SEQERR_n -> SEQ_ERR=0.
- S=0o20 or S=0o4000: SBWG_n -> RESTORE_PEND stays 0. RBK_n with BANK=5 -> BANK_BUS=16'h1400.
- In PEND, assert RESET -> S=0, BANK=0, RESTORE_PEND=0, SEQ_ERR=0. Also: SEQ_ERR set and clear in the same cycle -> SEQ_ERR=0.
